// File: rtl/gap_phase_sched.sv
// Phase/row sequencer for the GAP-TV datapath: issues buffer reads per
// (iteration, phase, frame, row) and replays them as writes PIPE_LAT cycles later.
`timescale 1ns/1ps
module gap_phase_sched #(
    parameter int ROW_NUM  = 48,
    parameter int ADDR_W   = 8,
    parameter int PIPE_LAT = 2,
    parameter int MAX_F    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        n_iter,
    input  logic [2:0]        f_num,
    input  logic              hold,
    input  logic              abort,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic              dx_diff_rst_n,
    output logic [1:0]        phase,
    output logic [7:0]        iter_cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SWEEP = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] PH_DX   = 2'd0;
    localparam logic [1:0] PH_PROJ = 2'd2;
    localparam logic [1:0] PH_IDLE = 2'd3;

    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROW_NUM - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_NUM);
    localparam logic [2:0]        F_MAX    = 3'(MAX_F);
    localparam int                DW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(PIPE_LAT - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        ph_q;
    logic [7:0]        iter_q;
    logic [7:0]        n_iter_q;
    logic [2:0]        f_q;
    logic [2:0]        frame_q;
    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] base_q;
    logic [DW-1:0]     drain_q;
    logic [2:0]        f_clamp;

    logic run_busy;
    logic kill;
    logic issue;
    logic row_last;
    logic frame_last;
    logic iter_last;
    logic drain_end;

    logic [PIPE_LAT-1:0] dl_v;
    logic [ADDR_W-1:0]   dl_a [PIPE_LAT];

    always_comb begin
        f_clamp = f_num;
        if (f_num == 3'd0) begin
            f_clamp = 3'd1;
        end else if (f_num > F_MAX) begin
            f_clamp = F_MAX;
        end
    end

    assign run_busy   = (state == S_SETUP) || (state == S_SWEEP) || (state == S_DRAIN);
    // abort outranks hold and also cancels whatever would be issued this cycle
    assign kill       = run_busy && abort;
    assign issue      = (state == S_SWEEP) && !hold && !kill;
    assign row_last   = (row_q == ROW_LAST);
    assign frame_last = (frame_q == (f_q - 3'd1));
    assign iter_last  = (({1'b0, iter_q} + 9'd1) >= {1'b0, n_iter_q});
    assign drain_end  = (drain_q == DRAIN_LAST);

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = (n_iter == 8'd0) ? S_DONE : S_SETUP;
                    end
                end
                S_SETUP: state_nxt = S_SWEEP;
                S_SWEEP: begin
                    if (issue && row_last) begin
                        state_nxt = frame_last ? S_DRAIN : S_SETUP;
                    end
                end
                S_DRAIN: begin
                    if (drain_end) begin
                        state_nxt = ((ph_q != PH_PROJ) || !iter_last) ? S_SETUP : S_DONE;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ph_q     <= PH_DX;
            iter_q   <= 8'd0;
            n_iter_q <= 8'd0;
            f_q      <= 3'd1;
            frame_q  <= 3'd0;
            row_q    <= '0;
            base_q   <= '0;
            drain_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_iter_q <= n_iter;
                        f_q      <= f_clamp;
                        iter_q   <= 8'd0;
                        ph_q     <= PH_DX;
                        frame_q  <= 3'd0;
                        base_q   <= '0;
                        row_q    <= '0;
                    end
                end
                S_SETUP: begin
                    row_q   <= '0;
                    drain_q <= '0;
                end
                S_SWEEP: begin
                    if (issue) begin
                        if (row_last) begin
                            row_q <= '0;
                            if (!frame_last) begin
                                frame_q <= frame_q + 3'd1;
                                base_q  <= base_q + ROW_STEP;
                            end
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_end) begin
                        drain_q <= '0;
                        frame_q <= 3'd0;
                        base_q  <= '0;
                        if (ph_q == PH_PROJ) begin
                            ph_q <= PH_DX;
                            if (!iter_last) begin
                                iter_q <= iter_q + 8'd1;
                            end
                        end else begin
                            ph_q <= ph_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Write delay line: every issued read re-emerges as a write PIPE_LAT cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_v <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_a[i] <= '0;
            end
        end else if (kill) begin
            dl_v <= '0;
        end else begin
            dl_v[0] <= issue;
            dl_a[0] <= raddr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
            end
        end
    end

    assign ren           = issue;
    assign raddr         = base_q + row_q;
    assign wen           = dl_v[PIPE_LAT-1] && !kill;
    assign waddr         = dl_a[PIPE_LAT-1];
    assign dx_diff_rst_n = !((state == S_SETUP) && (ph_q == PH_DX));
    assign phase         = run_busy ? ph_q : PH_IDLE;
    assign iter_cnt      = run_busy ? iter_q : 8'd0;
    assign busy          = run_busy;
    assign done          = (state == S_DONE);

endmodule

// File: tb/tb_gap_phase_sched.sv
// Bench for gap_phase_sched: builds a cycle-by-cycle expected trace from the
// loop structure (iteration/phase/frame/row) and compares the DUT against it.
`timescale 1ns/1ps
module tb_gap_phase_sched;
  localparam int ROW_NUM  = 48;
  localparam int ADDR_W   = 8;
  localparam int PIPE_LAT = 2;
  localparam int MAX_F    = 5;
  localparam int MAXC     = 4096;
  localparam int OW       = 15 + 2 * ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        n_iter = 8'd0;
  logic [2:0]        f_num = 3'd0;
  logic              hold = 1'b0;
  logic              abort = 1'b0;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic              dx_diff_rst_n;
  logic [1:0]        phase;
  logic [7:0]        iter_cnt;
  logic              busy;
  logic              done;

  gap_phase_sched #(
    .ROW_NUM(ROW_NUM), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT), .MAX_F(MAX_F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_iter(n_iter), .f_num(f_num),
    .hold(hold), .abort(abort), .ren(ren), .raddr(raddr), .wen(wen),
    .waddr(waddr), .dx_diff_rst_n(dx_diff_rst_n), .phase(phase),
    .iter_cnt(iter_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected trace and per-cycle drive values
  logic              e_busy [MAXC];
  logic              e_done [MAXC];
  logic              e_ren  [MAXC];
  logic              e_wen  [MAXC];
  logic              e_dxr  [MAXC];
  logic              e_rdc  [MAXC];
  logic [1:0]        e_phase[MAXC];
  logic [7:0]        e_iter [MAXC];
  logic [ADDR_W-1:0] e_raddr[MAXC];
  logic [ADDR_W-1:0] e_waddr[MAXC];
  logic              d_hold [MAXC];
  logic              d_start[MAXC];
  logic              d_abort[MAXC];
  int n_cyc;
  int mark_k;

  int hold_noise  = 0;
  int start_noise = 0;
  int stall_row   = -1;
  int stall_len   = 0;
  int mark_ph     = -1;
  int mark_row    = -1;
  int busy_seen;
  int max_ra;

  localparam logic [OW-1:0] RST_VEC = {1'b0, 1'b0, 2'd3, 8'd0, 1'b0, {ADDR_W{1'b0}},
                                       1'b0, {ADDR_W{1'b0}}, 1'b1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] pk(input logic b, input logic d, input logic [1:0] ph,
                                       input logic [7:0] it, input logic r,
                                       input logic [ADDR_W-1:0] ra, input logic w,
                                       input logic [ADDR_W-1:0] wa, input logic x,
                                       input logic rdc);
    logic r_eff;
    r_eff = r && !rdc;
    return {b, d, ph, (b ? it : 8'h00), r_eff, (r_eff ? ra : {ADDR_W{1'b0}}),
            w, (w ? wa : {ADDR_W{1'b0}}), x};
  endfunction

  function automatic logic [OW-1:0] raw_obs();
    return {busy, done, phase, iter_cnt, ren, raddr, wen, waddr, dx_diff_rst_n};
  endfunction

  function automatic logic rnd_hold();
    return (hold_noise != 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
  endfunction

  task automatic emit(input logic b, input logic d, input logic r, input logic x,
                      input int ph, input int it, input int ra, input logic h);
    e_busy[n_cyc]  = b;
    e_done[n_cyc]  = d;
    e_ren[n_cyc]   = r;
    e_dxr[n_cyc]   = x;
    e_rdc[n_cyc]   = 1'b0;
    e_phase[n_cyc] = 2'(ph);
    e_iter[n_cyc]  = 8'(it);
    e_raddr[n_cyc] = ADDR_W'(ra);
    e_wen[n_cyc]   = 1'b0;
    e_waddr[n_cyc] = '0;
    d_hold[n_cyc]  = h;
    d_abort[n_cyc] = 1'b0;
    d_start[n_cyc] = (start_noise != 0 && (b || d)) ? ($urandom_range(0, 15) == 0) : 1'b0;
    n_cyc++;
  endtask

  // Expected trace straight from the run structure: per phase, per frame one
  // setup cycle then ROW_NUM reads (stretched by hold), then PIPE_LAT drain cycles.
  task automatic build(input int ni, input int fn);
    int f;
    int row;
    int stall_left;
    logic stalled;
    logic h;
    n_cyc = 0;
    mark_k = -1;
    stall_left = 0;
    stalled = 1'b0;
    f = (fn == 0) ? 1 : ((fn > MAX_F) ? MAX_F : fn);
    for (int it = 0; it < ni; it++) begin
      for (int ph = 0; ph < 3; ph++) begin
        for (int fr = 0; fr < f; fr++) begin
          emit(1'b1, 1'b0, 1'b0, (ph != 0), ph, it, 0, rnd_hold());
          row = 0;
          while (row < ROW_NUM) begin
            if (stall_len > 0 && !stalled && ph == 0 && it == 0 && fr == 0 && row == stall_row) begin
              stalled = 1'b1;
              stall_left = stall_len;
            end
            if (stall_left > 0) begin
              emit(1'b1, 1'b0, 1'b0, 1'b1, ph, it, 0, 1'b1);
              stall_left--;
            end else begin
              h = rnd_hold();
              if (h) begin
                emit(1'b1, 1'b0, 1'b0, 1'b1, ph, it, 0, 1'b1);
              end else begin
                if (ph == mark_ph && it == 0 && fr == 0 && row == mark_row) mark_k = n_cyc;
                emit(1'b1, 1'b0, 1'b1, 1'b1, ph, it, fr * ROW_NUM + row, 1'b0);
                row++;
              end
            end
          end
        end
        for (int d = 0; d < PIPE_LAT; d++) emit(1'b1, 1'b0, 1'b0, 1'b1, ph, it, 0, rnd_hold());
      end
    end
    emit(1'b0, 1'b1, 1'b0, 1'b1, 3, 0, 0, rnd_hold());
    for (int i = 0; i < 3; i++) emit(1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 0, rnd_hold());
    for (int k = PIPE_LAT; k < n_cyc; k++) begin
      e_wen[k]   = e_ren[k-PIPE_LAT];
      e_waddr[k] = e_ren[k-PIPE_LAT] ? e_raddr[k-PIPE_LAT] : '0;
    end
  endtask

  // Abort at the marked read: nothing written from that cycle on, idle afterwards.
  task automatic apply_abort();
    int ka;
    ka = mark_k;
    d_abort[ka] = 1'b1;
    e_rdc[ka]   = 1'b1;
    e_wen[ka]   = 1'b0;
    e_waddr[ka] = '0;
    for (int k = ka + 1; k < ka + 5; k++) begin
      e_busy[k] = 1'b0; e_done[k] = 1'b0; e_ren[k] = 1'b0; e_wen[k] = 1'b0;
      e_dxr[k] = 1'b1; e_phase[k] = 2'd3; e_iter[k] = 8'd0; e_raddr[k] = '0;
      e_waddr[k] = '0; e_rdc[k] = 1'b0; d_start[k] = 1'b0; d_abort[k] = 1'b0;
    end
    n_cyc = ka + 5;
  endtask

  task automatic run(input int ni, input int fn, input string name, input int rst_k);
    busy_seen = 0;
    max_ra = 0;
    n_iter = 8'(ni);
    f_num = 3'(fn);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk);
      #1;
      start = d_start[k];
      hold  = d_hold[k];
      abort = d_abort[k];
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("%s_async_rst@%0d", name, k), raw_obs(), RST_VEC);
        break;
      end
      @(negedge clk);
      chk($sformatf("%s@%0d", name, k),
          pk(busy, done, phase, iter_cnt, ren, raddr, wen, waddr, dx_diff_rst_n, e_rdc[k]),
          pk(e_busy[k], e_done[k], e_phase[k], e_iter[k], e_ren[k], e_raddr[k],
             e_wen[k], e_waddr[k], e_dxr[k], e_rdc[k]));
      if (busy === 1'b1) busy_seen++;
      if (ren === 1'b1 && int'(raddr) > max_ra) max_ra = int'(raddr);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hold  = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni;
    int fn;
    #3;
    chk("reset_values", raw_obs(), RST_VEC);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    build(1, 1);
    run(1, 1, "basic", -1);
    chk("basic_busy_len", 64'(busy_seen), 64'd153);

    build(2, 5);
    run(2, 5, "multi", -1);
    chk("multi_busy_len", 64'(busy_seen), 64'd1482);
    chk("multi_max_raddr", 64'(max_ra), 64'd239);

    stall_row = 20;
    stall_len = 10;
    build(1, 1);
    run(1, 1, "stall", -1);
    stall_row = -1;
    stall_len = 0;

    build(0, 3);
    run(0, 3, "niter0", -1);
    chk("niter0_busy_len", 64'(busy_seen), 64'd0);

    hold_noise = 1;
    build(1, 0);
    run(1, 0, "f0", -1);

    start_noise = 1;
    build(1, 7);
    run(1, 7, "f7", -1);
    chk("f7_max_raddr", 64'(max_ra), 64'd239);
    hold_noise = 0;
    start_noise = 0;

    mark_ph = 1;
    mark_row = 30;
    build(1, 2);
    apply_abort();
    run(1, 2, "abort", -1);
    mark_ph = -1;
    mark_row = -1;
    build(1, 1);
    run(1, 1, "after_abort", -1);

    mark_ph = 2;
    mark_row = 10;
    build(1, 1);
    run(1, 1, "rst", mark_k);
    mark_ph = -1;
    mark_row = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", i), raw_obs(), RST_VEC);
    end
    build(1, 1);
    run(1, 1, "after_rst", -1);

    hold_noise = 1;
    start_noise = 1;
    for (int r = 0; r < 2; r++) begin
      ni = $urandom_range(1, 2);
      fn = $urandom_range(0, 7);
      build(ni, fn);
      run(ni, fn, $sformatf("rand%0d", r), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gap_phase_sched.md
Name: gap_phase_sched

Overview:
- Sequences the GAP-TV datapath over the frame buffer for one reconstruction run.
- For each iteration it runs three phases in order: DX difference, DY difference, then projection. Each phase sweeps every row of every frame through the read port, and the write port follows at a fixed pipeline latency.
- Owns the buffer's ren/raddr/wen/waddr and the dx_diff accumulator reset. Sits between the top-level run control and the gap_tv datapath/memory interface.

Parameters:
- ROW_NUM, 48, rows per frame (read/write words of PORT_SIZE pixels)
- ADDR_W, 8, buffer row-address width
- PIPE_LAT, 2, cycles from ren of a row to wen of the same row (range 1..7)
- MAX_F, 5, maximum frames; MAX_F*ROW_NUM must be <= 2^ADDR_W

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, sampled only in IDLE
- n_iter  in  8  iteration count, latched on accepted start
- f_num  in  3  frame count, latched on accepted start
- hold  in  1  stall: no new reads issued while high
- abort  in  1  synchronous run cancel
- ren  out  1  buffer read enable
- raddr  out  ADDR_W  buffer read row address
- wen  out  1  buffer write enable
- waddr  out  ADDR_W  buffer write row address
- dx_diff_rst_n  out  1  active-low clear of the dx_diff accumulator/counter
- phase  out  2  0=DX, 1=DY, 2=PROJ, 3=idle
- iter_cnt  out  8  current iteration, 0-based
- busy  out  1  run in progress
- done  out  1  one-cycle run-complete pulse

Behaviour:
- Reset: all outputs 0 except dx_diff_rst_n=1 and phase=3. State=IDLE. Write delay line cleared.
- Reset is asynchronous at any time, including mid-run; no pending write survives it.
- States: IDLE, SETUP, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 latches n_iter and F.
  - F is f_num clamped: 0 is treated as 1, and values >MAX_F are treated as MAX_F.
  - If n_iter=0, go to DONE. Otherwise go to SETUP with iter=0, phase=DX, frame=0.
- SETUP: one cycle per (phase, frame). ren=0. dx_diff_rst_n=0 only when phase=DX. row:=0. Next state is SWEEP.
- SWEEP:
  - Each cycle with hold=0: ren=1, raddr=frame*ROW_NUM+row, then row increments.
  - Each cycle with hold=1: ren=0; row and frame are frozen.
  - After row ROW_NUM-1 is issued: if frame<F-1, increment frame and go to SETUP; otherwise go to DRAIN.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles with ren=0. hold is ignored.
  - It then advances the phase: DX->DY->PROJ.
  - After PROJ: if iter<n_iter-1, increment iter and restart at DX, frame 0 (via SETUP). Otherwise go to DONE.
- Write path:
  - wen/waddr are ren/raddr delayed exactly PIPE_LAT cycles by a shift register, independent of hold.
  - The last wen of a phase falls in the last DRAIN cycle.
- DONE: one cycle with done=1 and busy=0, then IDLE.
- busy=1 in SETUP, SWEEP and DRAIN only.
- phase and iter_cnt are valid while busy; phase=3 otherwise.
- start while busy is ignored, including start asserted in the DONE cycle.
- abort=1 in any busy state:
  - Next cycle: ren=0, wen=0, delay line flushed (pending writes dropped), state=IDLE.
  - No done pulse is generated.
  - abort has priority over hold.
- Timing:
  - Cycles per phase with hold=0: F*(ROW_NUM+1)+PIPE_LAT.
  - Run length: n_iter*3*that value, plus 1 cycle for DONE.
- Addresses never exceed F*ROW_NUM-1. The row counter wraps only through SETUP, never modulo 2^ADDR_W.

Test Plan:
- Basic run, no stall: n_iter=1, f_num=1, hold=0.
  - busy high for 153 cycles. 3 sweeps, each raddr 0..47 contiguous.
  - Each wen/waddr equals ren/raddr 2 cycles later.
  - dx_diff_rst_n low 1 cycle before DX only. done pulses once, then IDLE.
- Multi-frame, multi-iteration: n_iter=2, f_num=5.
  - raddr covers 0..239 in each phase.
  - SETUP gap of 1 cycle at frame boundaries (47->48, 95->96, ...).
  - 6 phases in total; iter_cnt goes 0 then 1.
  - busy for 2*3*(5*49+2)=1482 cycles.
- Stall: hold high for 10 cycles mid-sweep at row 20 of DX.
  - ren=0 and raddr frozen; the two in-flight writes (rows 18,19) still complete.
  - Sweep resumes at row 20, with no duplicate or skipped rows.
- Edge values:
  - n_iter=0: done the cycle after start, no ren/wen.
  - f_num=0: behaves as F=1.
  - f_num=7: clamped to 5, max raddr 239.
  - start during busy: no effect.
- Abort: abort at DY row 30.
  - Next cycle ren=wen=0, state IDLE, no done.
  - Writes for rows 28/29 are suppressed.
  - A new start runs cleanly from DX row 0.
- Async reset mid-run: rst_n low at PROJ row 10.
  - All outputs immediately at reset values.
  - After release, no wen occurs until a new start.
